// File: rtl/wide_add_sequencer.sv
// ============================================================================
// wide_add_sequencer
//   Sequences a WIDTH-bit add through an external 2-bit adder, LSB slice first.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module wide_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [1:0]       fa_a,
  output logic [1:0]       fa_b,
  output logic             fa_cin,
  input  logic [1:0]       fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             busy
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] result_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Adder inputs are only presented while a slice is in flight.
  assign fa_a   = (state == RUN) ? a_sh[1:0] : 2'b00;
  assign fa_b   = (state == RUN) ? b_sh[1:0] : 2'b00;
  assign fa_cin = (state == RUN) ? carry : 1'b0;

  // New sum slice enters at the top; after SLICES shifts slice 0 lands at bit 0.
  assign result_next = {fa_sum, result};

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= op_a;
            b_sh   <= op_b;
            carry  <= op_cin;
            cnt    <= '0;
            result <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= result_next[WIDTH+1:2];
          carry  <= fa_cout;
          a_sh   <= a_sh >> 2;
          b_sh   <= b_sh >> 2;
          if (cnt == LAST_CNT) begin
            result_cout <= fa_cout;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
// ============================================================================
// tb_wide_add_sequencer
//   Scoreboard bench for wide_add_sequencer driving a behavioural 2-bit adder.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wide_add_sequencer;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic [1:0] fa_a;
  logic [1:0] fa_b;
  logic       fa_cin;
  logic [1:0] fa_sum;
  logic       fa_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       result_cout;
  logic       busy;
  logic [2:0] fa_total;

  typedef struct {
    logic [7:0] res;
    logic       cout;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #10 clk_50M = ~clk_50M;

  // Stand-in for the 2-bit ripple-carry adder on the fa_* ports.
  assign fa_total = {1'b0, fa_a} + {1'b0, fa_b} + {2'b00, fa_cin};
  assign fa_sum   = fa_total[1:0];
  assign fa_cout  = fa_total[2];

  wide_add_sequencer #(.WIDTH(8)) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .fa_a        (fa_a),
    .fa_b        (fa_b),
    .fa_cin      (fa_cin),
    .fa_sum      (fa_sum),
    .fa_cout     (fa_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_cout (result_cout),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pops and compares every accepted result.
  always @(negedge clk_50M) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("result_cout", 32'(result_cout), 32'(e.cout));
      end
    end
  end

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_result"}, 32'(result), 32'(0));
    check({tag, "_cout"}, 32'(result_cout), 32'(0));
    check({tag, "_fa"}, 32'({fa_a, fa_b, fa_cin}), 32'(0));
  endtask

  // Returns aligned at posedge+1 just after the accepting edge.
  task automatic send_start(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] total;
    int t;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    t = 0;
    @(negedge clk_50M);
    while (!in_ready && t < 50) begin
      @(negedge clk_50M);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'(0), 32'(1));
    total = {1'b0, a} + {1'b0, b} + {8'h00, cin};
    sb.push_back('{res: total[7:0], cout: total[8]});
    @(posedge clk_50M);
    #1;
    in_valid = 1'b0;
    op_a     = 8'($urandom);
    op_b     = 8'($urandom);
    op_cin   = 1'($urandom);
  endtask

  // Counts edges from acceptance until out_valid is seen; leaves at negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    @(negedge clk_50M);
    while (!out_valid && lat < 50) begin
      @(posedge clk_50M);
      lat++;
      @(negedge clk_50M);
    end
    if (!out_valid) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic add_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic cin);
    int lat;
    send_start(a, b, cin);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(4));
    @(posedge clk_50M);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    op_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk_50M);
    #1;
    check_idle_reset("por");
    reset = 1'b0;
    @(posedge clk_50M);
    #1;

    add_and_check("5a_3c", 8'h5A, 8'h3C, 1'b0);
    add_and_check("ff_01", 8'hFF, 8'h01, 1'b0);
    add_and_check("ff_ff_c1", 8'hFF, 8'hFF, 1'b1);
    add_and_check("00_00", 8'h00, 8'h00, 1'b0);

    // Backpressure: result must hold and no new operands captured.
    out_ready = 1'b0;
    add_and_check("bp", 8'h0F, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op_a     = 8'($urandom);
      op_b     = 8'($urandom);
      @(negedge clk_50M);
      check("bp_result", 32'(result), 32'(8'h10));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      @(posedge clk_50M);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk_50M);
    #1;
    @(negedge clk_50M);
    check("post_bp_in_ready", 32'(in_ready), 32'(1));
    check("post_bp_busy", 32'(busy), 32'(0));
    check("post_bp_held", 32'(result), 32'(8'h10));
    @(posedge clk_50M);
    #1;

    // Abort two slices into a run with an asynchronous reset.
    send_start(8'hA7, 8'h4E, 1'b1);
    @(negedge clk_50M);
    check("run_fa0", 32'({fa_a, fa_b, fa_cin}), 32'({2'd3, 2'd2, 1'b1}));
    @(posedge clk_50M);
    @(negedge clk_50M);
    check("run_fa1", 32'({fa_a, fa_b, fa_cin}), 32'({2'd1, 2'd3, 1'b1}));
    check("run_busy", 32'(busy), 32'(1));
    @(posedge clk_50M);
    #5;
    reset = 1'b1;
    #1;
    check_idle_reset("abort");
    sb.delete();
    @(posedge clk_50M);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50M);
      check("abort_no_valid", 32'(out_valid), 32'(0));
    end
    @(posedge clk_50M);
    #1;
    add_and_check("12_34", 8'h12, 8'h34, 1'b0);

    for (int i = 0; i < 6; i++) begin
      add_and_check("rand", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk_50M);
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
